// File: rtl/mont_modexp_ctrl_if.sv
// Request-side bus of the Montgomery modexp sequencer: operands in, busy/done/result out,
// plus the sequencer's FSM state for observation.
interface mont_modexp_ctrl_if #(
    parameter int DW    = 32,
    parameter int EXP_W = 32
);
    logic             start;
    logic [DW-1:0]    base_m;
    logic [EXP_W-1:0] exp;
    logic [DW-1:0]    one_m;
    logic             busy;
    logic             done;
    logic [DW-1:0]    result;
    logic [1:0]       fsm_state;

    modport master (
        output start, base_m, exp, one_m,
        input  busy, done, result, fsm_state
    );

    modport slave (
        input  start, base_m, exp, one_m,
        output busy, done, result, fsm_state
    );
endinterface

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer feeding a fixed-latency Montgomery multiplier.
// Optional leading-zero skipping of the exponent is enabled by defining MONT_MODEXP_LZ_SKIP_EN.
module mont_modexp_ctrl #(
    parameter int DW      = 32,
    parameter int EXP_W   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mont_modexp_ctrl_if.slave    req,
    output logic [DW-1:0]        mul_a,
    output logic [DW-1:0]        mul_b,
    input  logic [DW-1:0]        mul_res
);
    // Handshake: start is sampled only in IDLE; busy is high from the cycle after an
    // accepted start through the DONE cycle; done is a one-cycle pulse with result valid.
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    localparam logic PH_SQR = 1'b0;
    localparam logic PH_MUL = 1'b1;

    state_t           state, state_nx;
    logic             phase, phase_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic [DW-1:0]    acc, acc_nx;
    logic [DW-1:0]    base_r, base_nx;
    logic [EXP_W-1:0] exp_r, exp_nx;
    logic [DW-1:0]    result_r, result_nx;

`ifdef MONT_MODEXP_LZ_SKIP_EN
    function automatic logic [IW-1:0] msb_index(input logic [EXP_W-1:0] e);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < EXP_W; k++) begin
            if (e[k]) r = IW'(k);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= PH_SQR;
            cnt      <= '0;
            idx      <= '0;
            acc      <= '0;
            base_r   <= '0;
            exp_r    <= '0;
            result_r <= '0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            acc      <= acc_nx;
            base_r   <= base_nx;
            exp_r    <= exp_nx;
            result_r <= result_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        cnt_nx    = cnt;
        idx_nx    = idx;
        acc_nx    = acc;
        base_nx   = base_r;
        exp_nx    = exp_r;
        result_nx = result_r;

        case (state)
            S_IDLE: begin
                if (req.start) begin
                    base_nx  = req.base_m;
                    exp_nx   = req.exp;
                    acc_nx   = req.one_m;
                    phase_nx = PH_SQR;
`ifdef MONT_MODEXP_LZ_SKIP_EN
                    if (req.exp == '0) begin
                        result_nx = req.one_m;
                        state_nx  = S_DONE;
                    end else begin
                        idx_nx   = msb_index(req.exp);
                        state_nx = S_ISSUE;
                    end
`else
                    idx_nx   = IW'(EXP_W - 1);
                    state_nx = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                cnt_nx   = CW'(MUL_LAT - 1);
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    // Multiplier output is kept as-is, including the value q.
                    acc_nx = mul_res;
                    if (phase == PH_SQR && exp_r[idx]) begin
                        phase_nx = PH_MUL;
                        state_nx = S_ISSUE;
                    end else if (idx == '0) begin
                        result_nx = mul_res;
                        state_nx  = S_DONE;
                    end else begin
                        idx_nx   = idx - 1'b1;
                        phase_nx = PH_SQR;
                        state_nx = S_ISSUE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req.busy      = (state != S_IDLE);
        req.done      = (state == S_DONE);
        req.result    = result_r;
        req.fsm_state = state;
        mul_a         = '0;
        mul_b         = '0;
        if (state == S_ISSUE || state == S_WAIT) begin
            mul_a = acc;
            mul_b = (phase == PH_MUL) ? base_r : acc;
        end
    end
endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Directed bench for mont_modexp_ctrl with a behavioural 5-stage multiplier for q=17 (R mod q = 1).
module tb_mont_modexp_ctrl;
    localparam int DW      = 32;
    localparam int EXP_W   = 32;
    localparam int MUL_LAT = 5;
`ifdef MONT_MODEXP_LZ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic clk;
    logic rst;
    logic [DW-1:0] mul_a, mul_b, mul_res;
    logic [DW-1:0] pipe [0:MUL_LAT-1];

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_res;

    mont_modexp_ctrl_if #(.DW(DW), .EXP_W(EXP_W)) bus ();

    mont_modexp_ctrl #(.DW(DW), .EXP_W(EXP_W), .MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (bus),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_res (mul_res)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: with R mod 17 = 1 the Montgomery product is a*b mod 17.
    always_ff @(posedge clk) begin
        pipe[0] <= DW'(({32'b0, mul_a} * {32'b0, mul_b}) % 64'd17);
        for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_res = pipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, want);
        end
    endtask

    // Start one op in the cycle after the current one (cycle 0) and follow it to done.
    task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] res, input int want_cyc, input bit repulse);
        int cyc, done_cyc, busy_bad, unstable;
        logic [DW-1:0] pa, pb, want_res;
        @(posedge clk); #1;
        check({tag, "_pre_done"}, {63'b0, bus.done}, 64'd0);
        check({tag, "_pre_busy"}, {63'b0, bus.busy}, 64'd0);
        check({tag, "_held_result"}, {32'b0, bus.result}, {32'b0, last_res});
        exp_q.push_back(res);
        bus.start = 1'b1; bus.base_m = b; bus.exp = e; bus.one_m = 32'd1;
        cyc = 0; done_cyc = -1; busy_bad = 0; unstable = 0;
        pa = mul_a; pb = mul_b;
        while (cyc < 500 && done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (repulse) begin
                bus.base_m = 32'd7; bus.exp = 32'h0000ffff;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.busy) busy_bad++;
            if (bus.fsm_state == ST_WAIT && (mul_a !== pa || mul_b !== pb)) unstable++;
            pa = mul_a; pb = mul_b;
            if (bus.done) done_cyc = cyc;
        end
        bus.start = 1'b0;
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(want_cyc));
        check({tag, "_busy_span"}, 64'(busy_bad), 64'd0);
        check({tag, "_operand_hold"}, 64'(unstable), 64'd0);
        want_res = exp_q.pop_front();
        check({tag, "_result"}, {32'b0, bus.result}, {32'b0, want_res});
        last_res = want_res;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.base_m = '0; bus.exp = '0; bus.one_m = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {63'b0, bus.busy}, 64'd0);
        check("rst_done",   {63'b0, bus.done}, 64'd0);
        check("rst_result", {32'b0, bus.result}, 64'd0);
        check("rst_mul_a",  {32'b0, mul_a}, 64'd0);
        check("rst_mul_b",  {32'b0, mul_b}, 64'd0);
        rst = 1'b0;

        run_op("b3e5", 32'd3, 32'd5, 32'd5, SKIP ? 31 : 205, 1'b0);
        run_op("b2e8", 32'd2, 32'd8, 32'd1, SKIP ? 31 : 199, 1'b0);
        run_op("b9e0", 32'd9, 32'd0, 32'd1, SKIP ? 1 : 193, 1'b0);

        // start held high for the whole run, then a fresh start right after done
        run_op("repulse", 32'd3, 32'd16, 32'd1, SKIP ? 37 : 199, 1'b1);
        run_op("after_repulse", 32'd5, 32'd2, 32'd8, SKIP ? 19 : 199, 1'b0);

        // reset in cycle 50 of a long run
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_m = 32'd3; bus.exp = 32'hffffffff; bus.one_m = 32'd1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy",   {63'b0, bus.busy}, 64'd0);
        check("midrst_done",   {63'b0, bus.done}, 64'd0);
        check("midrst_result", {32'b0, bus.result}, 64'd0);
        check("midrst_mul_a",  {32'b0, mul_a}, 64'd0);
        check("midrst_mul_b",  {32'b0, mul_b}, 64'd0);
        rst = 1'b0;
        last_res = '0;
        run_op("post_rst", 32'd3, 32'd16, 32'd1, SKIP ? 37 : 199, 1'b0);

        // back-to-back
        run_op("b5e2", 32'd5, 32'd2, 32'd8, SKIP ? 19 : 199, 1'b0);
        run_op("b5e3", 32'd5, 32'd3, 32'd6, SKIP ? 25 : 205, 1'b0);

        @(posedge clk); #1;
        check("final_done",   {63'b0, bus.done}, 64'd0);
        check("final_result", {32'b0, bus.result}, 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
